// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse init sequencer: sends FF (reset), optionally F3 + rate, then F4 and
// checks each reply. Build option PS2_RATE_CFG_EN adds the F3/SAMPLE_RATE pair.
module ps2_mouse_init_ctrl #(
  parameter int          CLK_HZ      = 100_000_000,
  parameter int          TIMEOUT_MS  = 20,
  parameter int          BAT_MS      = 750,
  parameter int          MAX_RETRY   = 3,
  parameter logic [7:0]  SAMPLE_RATE = 8'd100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       init_done,
  output logic       init_err,
  output logic       stream_en,
  output logic [1:0] retry_cnt
);

  localparam logic [7:0] B_ACK    = 8'hFA;
  localparam logic [7:0] B_BAT_OK = 8'hAA;
  localparam logic [7:0] B_ID     = 8'h00;
  localparam logic [7:0] B_RESEND = 8'hFE;
  localparam logic [7:0] B_FAIL   = 8'hFC;

  // Product computed in 64 bits: BAT_MS * CLK_HZ overflows 32 bits at default values.
  localparam longint BAT_LIM   = longint'(BAT_MS) * longint'(CLK_HZ) / 1000;
  localparam longint REPLY_LIM = longint'(TIMEOUT_MS) * longint'(CLK_HZ) / 1000;
  localparam longint MAX_LIM   = (BAT_LIM > REPLY_LIM) ? BAT_LIM : REPLY_LIM;
  localparam int     CNT_W     = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;

  localparam logic [CNT_W-1:0] BAT_LAST   = CNT_W'(BAT_LIM - 1);
  localparam logic [CNT_W-1:0] REPLY_LAST = CNT_W'(REPLY_LIM - 1);

`ifdef PS2_RATE_CFG_EN
  localparam logic [1:0] LAST_IDX = 2'd3;

  function automatic logic [7:0] cmd_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'hFF;
      2'd1:    return 8'hF3;
      2'd2:    return SAMPLE_RATE;
      default: return 8'hF4;
    endcase
  endfunction
`else
  localparam logic [1:0] LAST_IDX = 2'd1;

  function automatic logic [7:0] cmd_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'hFF;
      default: return 8'hF4;
    endcase
  endfunction
`endif

  typedef enum logic [3:0] {
    IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID, NEXT, DONE, ERR
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [1:0]       retry_nxt;
  logic [1:0]       fe_cnt, fe_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             fail;
  logic [7:0]       exp_byte;
  state_t           after_reply;

  assign tmo_hit = (state == WAIT_BAT) ? (tmo_cnt >= BAT_LAST) : (tmo_cnt >= REPLY_LAST);

  // Index 0 is always FF, the only command with the BAT/ID reply tail.
  always_comb begin
    exp_byte    = B_ACK;
    after_reply = NEXT;
    case (state)
      WAIT_ACK: after_reply = (idx == 2'd0) ? WAIT_BAT : NEXT;
      WAIT_BAT: begin exp_byte = B_BAT_OK; after_reply = WAIT_ID; end
      WAIT_ID:  begin exp_byte = B_ID;     after_reply = NEXT;    end
      default: ;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry_cnt;
    fe_nxt    = fe_cnt;
    fail      = 1'b0;

    case (state)
      IDLE: ;
      SEND:    if (!tx_busy) state_nxt = WAIT_TX;
      WAIT_TX: begin
        if (tx_done)      state_nxt = WAIT_ACK;
        else if (tmo_hit) fail      = 1'b1;
      end
      WAIT_ACK, WAIT_BAT, WAIT_ID: begin
        // A received byte in the timeout cycle takes precedence over the timeout.
        if (rx_valid) begin
          if (rx_data == exp_byte) begin
            state_nxt = after_reply;
          end else if (rx_data == B_RESEND) begin
            if (fe_cnt == 2'd2) begin
              fail = 1'b1;
            end else begin
              fe_nxt    = fe_cnt + 2'd1;
              state_nxt = SEND;
            end
          end else if (rx_data == B_FAIL) begin
            state_nxt = ERR;
          end
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      NEXT: begin
        fe_nxt = 2'd0;
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 2'd1;
          state_nxt = SEND;
        end
      end
      DONE, ERR: ;
      default: state_nxt = IDLE;
    endcase

    if (fail) begin
      fe_nxt  = 2'd0;
      idx_nxt = 2'd0;
      if (int'(retry_cnt) < MAX_RETRY) begin
        retry_nxt = retry_cnt + 2'd1;
        state_nxt = SEND;
      end else begin
        state_nxt = ERR;
      end
    end

    if (start) begin
      state_nxt = SEND;
      idx_nxt   = 2'd0;
      retry_nxt = 2'd0;
      fe_nxt    = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= 2'd0;
      retry_cnt <= 2'd0;
      fe_cnt    <= 2'd0;
      tmo_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_nxt;
      idx       <= idx_nxt;
      retry_cnt <= retry_nxt;
      fe_cnt    <= fe_nxt;
      if (state_nxt != state) tmo_cnt <= '0;
      else if (!tmo_hit)      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // A start in the SEND cycle suppresses the request so the restart begins cleanly.
  assign tx_start  = (state == SEND) && !tx_busy && !start;
  assign tx_data   = (state == SEND) ? cmd_byte(idx) : 8'h00;
  assign init_done = (state == DONE);
  assign init_err  = (state == ERR);
  assign stream_en = init_done;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Scoreboard bench for ps2_mouse_init_ctrl: a scripted device model drives replies,
// a reference model predicts the command stream and the final status.
`timescale 1ns/1ps
module tb_ps2_mouse_init_ctrl;

  localparam int         CLK_HZ      = 10_000;
  localparam int         TIMEOUT_MS  = 2;
  localparam int         BAT_MS      = 5;
  localparam int         MAX_RETRY   = 3;
  localparam logic [7:0] SAMPLE_RATE = 8'd100;
`ifdef PS2_RATE_CFG_EN
  localparam int N_CMD = 4;
`else
  localparam int N_CMD = 2;
`endif

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic       tx_busy = 1'b0, tx_done = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_start, init_done, init_err, stream_en;
  logic [7:0] tx_data;
  logic [1:0] retry_cnt;

  ps2_mouse_init_ctrl #(
    .CLK_HZ(CLK_HZ), .TIMEOUT_MS(TIMEOUT_MS), .BAT_MS(BAT_MS),
    .MAX_RETRY(MAX_RETRY), .SAMPLE_RATE(SAMPLE_RATE)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .init_done(init_done), .init_err(init_err), .stream_en(stream_en),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  // Device behaviour for one transmitted command.
  typedef enum int { A_OK, A_FE, A_FC, A_SILENT, A_NOBAT, A_RESTART } act_t;

  act_t       acts[$];
  logic [7:0] exp_q[$];
  bit         exp_done, exp_err;
  int         exp_retry;
  int         n_checks = 0;
  int         n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cmd_at(input int i);
`ifdef PS2_RATE_CFG_EN
    case (i)
      0:       return 8'hFF;
      1:       return 8'hF3;
      2:       return SAMPLE_RATE;
      default: return 8'hF4;
    endcase
`else
    return (i == 0) ? 8'hFF : 8'hF4;
`endif
  endfunction

  // Reference: walk the command list consuming one device behaviour per transmission.
  task automatic build_expected();
    int   idx = 0, retry = 0, fe = 0, k = 0;
    bit   fin = 0, tmo;
    act_t a;
    exp_done = 0;
    exp_err  = 0;
    while (!fin) begin
      exp_q.push_back(cmd_at(idx));
      a = (k < acts.size()) ? acts[k] : A_OK;
      k++;
      tmo = 0;
      case (a)
        A_OK:      begin fe = 0; idx++; if (idx == N_CMD) begin exp_done = 1; fin = 1; end end
        A_FE:      begin fe++; if (fe == 3) tmo = 1; end
        A_FC:      begin exp_err = 1; fin = 1; end
        A_RESTART: begin idx = 0; retry = 0; fe = 0; end
        default:   tmo = 1;
      endcase
      if (tmo) begin
        fe  = 0;
        idx = 0;
        if (retry < MAX_RETRY) retry++;
        else begin exp_err = 1; fin = 1; end
      end
    end
    exp_retry = retry;
  endtask

  // Monitor: every tx_start must match the next predicted command byte.
  always @(negedge clk) begin
    if (tx_start) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL tx_unexpected: got tx_data %0h, expected no tx_start", tx_data);
      end else begin
        check("tx_byte", tx_data, exp_q.pop_front());
      end
    end
  end

  task automatic pulse_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Optional ignorable junk byte and idle gap before the real reply byte.
  task automatic send_byte(input logic [7:0] b);
    if ($urandom_range(0, 2) == 0) pulse_rx(8'h10 + 8'($urandom_range(0, 8'h6F)));
    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin @(posedge clk); #1; end
    pulse_rx(b);
  endtask

  task automatic run_scenario(input string tag);
    logic [7:0] sent;
    act_t       a;
    int         k = 0;
    bit         got;
    build_expected();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, " cleared"}, {init_done, init_err, stream_en}, 3'b000);
    check({tag, " retry_clr"}, retry_cnt, 2'd0);
    while (!(init_done || init_err)) begin
      got = 0;
      for (int c = 0; c < 300 && !got && !(init_done || init_err); c++) begin
        @(negedge clk);
        got = tx_start;
      end
      if (!got && (init_done || init_err)) break;
      n_checks++;
      if (!got) begin
        n_errs++;
        $display("FAIL %s tx_wait: got no tx_start in 300 cycles, expected one", tag);
        break;
      end
      sent = tx_data;
      a = (k < acts.size()) ? acts[k] : A_OK;
      k++;
      @(posedge clk); #1 tx_busy = 1'b1;
      repeat (2) @(posedge clk);
      #1 tx_busy = 1'b0; tx_done = 1'b1;
      @(posedge clk); #1 tx_done = 1'b0;
      case (a)
        A_OK: begin
          send_byte(8'hFA);
          if (sent == 8'hFF) begin send_byte(8'hAA); send_byte(8'h00); end
        end
        A_FE:    send_byte(8'hFE);
        A_FC: begin
          send_byte(8'hFC);
          check({tag, " err_after_fc"}, init_err, 1'b1);
        end
        A_NOBAT: if (sent == 8'hFF) send_byte(8'hFA);
        A_RESTART: begin
          tx_busy = 1'b1;
          start   = 1'b1;
          @(posedge clk); #1 start = 1'b0;
          for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check({tag, " busy_hold"}, tx_start, 1'b0);
          end
          check({tag, " restart_clr"}, {init_done, init_err, stream_en, retry_cnt}, 5'd0);
          @(posedge clk); #1 tx_busy = 1'b0;
        end
        default: ;
      endcase
    end
    repeat (30) @(negedge clk);
    check({tag, " init_done"}, init_done, exp_done);
    check({tag, " init_err"}, init_err, exp_err);
    check({tag, " stream_en"}, stream_en, exp_done);
    check({tag, " retry_cnt"}, retry_cnt, exp_retry);
    check({tag, " left_over"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int len, r;
    #12;
    check("reset_outs", {tx_start, init_done, init_err, stream_en, retry_cnt}, 6'd0);
    check("reset_txd", tx_data, 8'h00);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);

    acts.delete();
    run_scenario("T1");
    acts = '{A_OK, A_FE, A_OK};
    run_scenario("T2a");
    acts = '{A_OK, A_FE, A_FE, A_FE, A_OK, A_OK};
    run_scenario("T2b");
    acts = '{A_FC};
    run_scenario("T4");
    acts = '{A_RESTART, A_OK, A_OK};
    run_scenario("T5");
    acts = '{A_NOBAT, A_NOBAT, A_NOBAT, A_NOBAT};
    run_scenario("T3");

    // Asynchronous reset while holding the error state with retries used.
    #3 reset = 1'b0;
    #1;
    check("async_rst", {init_done, init_err, stream_en, retry_cnt, tx_start}, 6'd0);
    @(negedge clk) reset = 1'b1;
    repeat (10) @(negedge clk);

    for (int s = 0; s < 8; s++) begin
      acts.delete();
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 11);
        if (r < 6)       acts.push_back(A_OK);
        else if (r < 8)  acts.push_back(A_FE);
        else if (r == 8) acts.push_back(A_SILENT);
        else if (r == 9) acts.push_back(A_NOBAT);
        else if (r == 10) acts.push_back(A_FE);
        else             acts.push_back(A_FC);
      end
      run_scenario($sformatf("R%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
